// File: rtl/reg_file_pkg.sv
// Shared defaults and helpers for the parametrised general-purpose register file.
package reg_file_pkg;

    localparam int unsigned XLEN_DEF   = 32;
    localparam int unsigned LANE_W_DEF = 16;
    localparam int unsigned NREGS_DEF  = 8;

    function automatic int unsigned lanes(input int unsigned xlen, input int unsigned lane_w);
        return xlen / lane_w;
    endfunction

    typedef logic [$clog2(NREGS_DEF)-1:0] reg_idx_t;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-write scoreboard: one bit per register set by decode reservations and
// cleared by writeback, plus a registered population count.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int unsigned NREGS   = NREGS_DEF,
    parameter int unsigned NRD     = 2,
    parameter int unsigned ZERO_R0 = 0,
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_en,
    input  logic [AW-1:0]     clr_addr,
    input  logic              set_req,
    input  logic [AW-1:0]     set_addr,
    output logic              set_ready,
    input  logic [NRD*AW-1:0] look_addr,
    output logic [NRD-1:0]    look_busy,
    output logic [NREGS-1:0]  pending,
    output logic [AW:0]       npend
);

    logic [NREGS-1:0] pending_q, pending_d;
    logic [AW:0]      npend_q, npend_d;
    logic             set_eff, clr_eff;

    always_comb begin
        set_ready = set_req && !pending_q[set_addr] && !reset;
        // Register 0 accepts reservations but never records them when hardwired.
        set_eff   = set_ready && !((ZERO_R0 != 0) && (set_addr == '0));
        // An accepted set implies its bit was clear, so a same-address clear never counts.
        clr_eff   = clr_en && pending_q[clr_addr];

        pending_d = pending_q;
        if (clr_en) pending_d[clr_addr] = 1'b0;
        if (set_eff) pending_d[set_addr] = 1'b1;

        npend_d = npend_q;
        case ({set_eff, clr_eff})
            2'b10:   npend_d = npend_q + (AW+1)'(1);
            2'b01:   npend_d = npend_q - (AW+1)'(1);
            default: npend_d = npend_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            npend_q   <= '0;
        end else begin
            pending_q <= pending_d;
            npend_q   <= npend_d;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_look
        logic [AW-1:0] la;
        assign la           = look_addr[k*AW +: AW];
        assign look_busy[k] = pending_q[la] && !(clr_en && (clr_addr == la));
    end

    assign pending = pending_q;
    assign npend   = npend_q;

endmodule

// File: rtl/param_reg_file.sv
// NREGS x XLEN register file with lane-granular writes, same-cycle write bypass on
// every read port and a pending-write scoreboard for hazard detection.
module param_reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned LANE_W  = LANE_W_DEF,
    parameter int unsigned NREGS   = NREGS_DEF,
    parameter int unsigned NRD     = 2,
    parameter int unsigned ZERO_R0 = 0,
    localparam int unsigned LANES  = lanes(XLEN, LANE_W),
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [LANES-1:0]    we,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic                rsv_valid,
    input  logic [AW-1:0]       rsv_addr,
    output logic                rsv_ready,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    output logic [NREGS-1:0]    pending,
    output logic [AW:0]         npend
);

    logic wr_allow;
    assign wr_allow = !((ZERO_R0 != 0) && (waddr == '0));

    // Storage is split per lane so each lane's write enable owns its own array.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [LANE_W-1:0] lane_q [NREGS];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                lane_q <= '{default: '0};
            end else if (we[g] && wr_allow) begin
                lane_q[waddr] <= wdata[g*LANE_W +: LANE_W];
            end
        end

        for (genvar k = 0; k < NRD; k++) begin : g_port
            logic [AW-1:0] ra;
            logic          rd_zero;
            assign ra      = raddr[k*AW +: AW];
            assign rd_zero = reset || ((ZERO_R0 != 0) && (ra == '0));
            assign rdata[k*XLEN + g*LANE_W +: LANE_W] =
                rd_zero                  ? '0 :
                (we[g] && waddr == ra)   ? wdata[g*LANE_W +: LANE_W] :
                                           lane_q[ra];
        end
    end

    reg_file_scoreboard #(
        .NREGS   (NREGS),
        .NRD     (NRD),
        .ZERO_R0 (ZERO_R0)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .clr_en    (|we),
        .clr_addr  (waddr),
        .set_req   (rsv_valid),
        .set_addr  (rsv_addr),
        .set_ready (rsv_ready),
        .look_addr (raddr),
        .look_busy (rbusy),
        .pending   (pending),
        .npend     (npend)
    );

endmodule
